// File: rtl/display_timing_gen.sv
// display_timing_gen: raster timing generator with pixel/line counters, visible-area flag, delayed active-low syncs and a frame counter
//   clk, rst_n  : system clock, asynchronous active-low reset
//   pix_en      : pixel-rate tick; counters advance only when high
//   pix_col/row : current horizontal/vertical position
//   video_on    : registered visible-area flag for the driven position
//   hsync/vsync : active-low syncs, delayed SYNC_DELAY clks to match downstream latency
//   frame_tick  : one-clk pulse at the start of vertical blanking
//   frame_count : completed frames, wrapping
module display_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_DELAY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_en,
  output logic [9:0]  pix_col,
  output logic [9:0]  pix_row,
  output logic        video_on,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_tick,
  output logic [15:0] frame_count
);
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  logic [9:0]  r_col, r_row;
  logic        r_video_on, r_frame_tick;
  logic [15:0] r_frame_count;
  logic [9:0]  w_col_nxt, w_row_nxt;
  logic        w_col_last, w_frame_start, w_hs_raw, w_vs_raw;
  always_comb begin
    w_col_last    = r_col == H_LAST;
    w_col_nxt     = w_col_last ? '0 : r_col + 10'd1;
    w_row_nxt     = !w_col_last ? r_row : (r_row == V_LAST) ? '0 : r_row + 10'd1;
    w_frame_start = pix_en && w_col_last && (r_row == V_VIS - 10'd1);
    w_hs_raw      = !(r_col >= HS_BEG && r_col < HS_END);
    w_vs_raw      = !(r_row >= VS_BEG && r_row < VS_END);
  end
  // video_on is computed from the next position so it lines up with the counters it is registered alongside
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col         <= '0;
      r_row         <= '0;
      r_video_on    <= 1'b0;
      r_frame_tick  <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_frame_tick <= w_frame_start;
      if (w_frame_start) r_frame_count <= r_frame_count + 16'd1;
      if (pix_en) begin
        r_col      <= w_col_nxt;
        r_row      <= w_row_nxt;
        r_video_on <= (w_col_nxt < H_VIS) && (w_row_nxt < V_VIS);
      end
    end
  end
  generate
    if (SYNC_DELAY == 0) begin : g_nodly
      assign hsync = w_hs_raw;
      assign vsync = w_vs_raw;
    end else begin : g_dly
      // shifts every clk regardless of pix_en; the cast drops the oldest stage
      logic [SYNC_DELAY-1:0] r_hs_sr, r_vs_sr;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_hs_sr <= '1;
          r_vs_sr <= '1;
        end else begin
          r_hs_sr <= SYNC_DELAY'({r_hs_sr, w_hs_raw});
          r_vs_sr <= SYNC_DELAY'({r_vs_sr, w_vs_raw});
        end
      end
      assign hsync = r_hs_sr[SYNC_DELAY-1];
      assign vsync = r_vs_sr[SYNC_DELAY-1];
    end
  endgenerate
  assign pix_col     = r_col;
  assign pix_row     = r_row;
  assign video_on    = r_video_on;
  assign frame_tick  = r_frame_tick;
  assign frame_count = r_frame_count;
endmodule

// File: tb/tb_display_timing_gen.sv
// tb_display_timing_gen: directed checks of a default-timing instance and two small-raster instances (sync delay 3 and 0)
module tb_display_timing_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;
  logic [9:0] a_col, a_row, b_col, b_row, c_col, c_row;
  logic a_von, a_hs, a_vs, a_ft, b_von, b_hs, b_vs, b_ft, c_von, c_hs, c_vs, c_ft;
  logic [15:0] a_fc, b_fc, c_fc;
  int n_vec = 0;
  int n_err = 0;
  int k_now = 0;
  int qcnt = 0;
  always #5 clk = ~clk;
  display_timing_gen dut_a (
    .clk(clk), .rst_n(rst_n), .pix_en(en), .pix_col(a_col), .pix_row(a_row), .video_on(a_von),
    .hsync(a_hs), .vsync(a_vs), .frame_tick(a_ft), .frame_count(a_fc));
  display_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .SYNC_DELAY(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .pix_en(en), .pix_col(b_col), .pix_row(b_row), .video_on(b_von),
    .hsync(b_hs), .vsync(b_vs), .frame_tick(b_ft), .frame_count(b_fc));
  display_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .SYNC_DELAY(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .pix_en(en), .pix_col(c_col), .pix_row(c_row), .video_on(c_von),
    .hsync(c_hs), .vsync(c_vs), .frame_tick(c_ft), .frame_count(c_fc));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic adv_to(input int k);
    while (k_now < k) begin
      @(negedge clk);
      k_now++;
    end
  endtask
  task automatic qstep(input int target);
    while (qcnt < target) begin
      en = (qcnt % 4 == 0);
      @(negedge clk);
      qcnt++;
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_col", 32'(a_col), 0);
    chk("rst_row", 32'(a_row), 0);
    chk("rst_von", 32'(a_von), 0);
    chk("rst_hs", 32'(a_hs), 1);
    chk("rst_vs", 32'(a_vs), 1);
    chk("rst_ft", 32'(a_ft), 0);
    chk("rst_fc", 32'(a_fc), 0);
    chk("rst_c_hs", 32'(c_hs), 1);
    rst_n = 1'b1;
    adv_to(1);    chk("a_col1", 32'(a_col), 1); chk("a_von1", 32'(a_von), 1);
    adv_to(9);    chk("c_hs9", 32'(c_hs), 1);
    adv_to(10);   chk("c_hs10", 32'(c_hs), 0);
    adv_to(12);   chk("b_hs12", 32'(b_hs), 1);
    adv_to(13);   chk("b_hs13", 32'(b_hs), 0);
    adv_to(16);   chk("b_hs16", 32'(b_hs), 1); chk("b_col16", 32'(b_col), 0); chk("b_row16", 32'(b_row), 1);
    adv_to(95);   chk("b_ft95", 32'(b_ft), 0);
    adv_to(96);   chk("b_ft96", 32'(b_ft), 1); chk("b_fc96", 32'(b_fc), 1);
                  chk("b_row96", 32'(b_row), 6); chk("b_col96", 32'(b_col), 0); chk("b_von96", 32'(b_von), 0);
    adv_to(97);   chk("b_ft97", 32'(b_ft), 0);
    adv_to(130);  chk("b_vs130", 32'(b_vs), 1);
    adv_to(131);  chk("b_vs131", 32'(b_vs), 0);
    adv_to(162);  chk("b_vs162", 32'(b_vs), 0);
    adv_to(163);  chk("b_vs163", 32'(b_vs), 1);
    adv_to(191);  chk("b_row191", 32'(b_row), 11); chk("b_col191", 32'(b_col), 15);
    adv_to(192);  chk("b_row192", 32'(b_row), 0); chk("b_col192", 32'(b_col), 0);
    adv_to(323);  chk("b_vs323", 32'(b_vs), 0);
    adv_to(480);  chk("b_fc480", 32'(b_fc), 3);
    adv_to(639);  chk("a_von639", 32'(a_von), 1);
    adv_to(640);  chk("a_von640", 32'(a_von), 0);
    adv_to(657);  chk("a_hs657", 32'(a_hs), 1); chk("a_col657", 32'(a_col), 657);
    adv_to(658);  chk("a_hs658", 32'(a_hs), 0);
    adv_to(753);  chk("a_hs753", 32'(a_hs), 0);
    adv_to(754);  chk("a_hs754", 32'(a_hs), 1);
    adv_to(800);  chk("a_col800", 32'(a_col), 0); chk("a_row800", 32'(a_row), 1); chk("a_von800", 32'(a_von), 1);
    adv_to(1457); chk("a_hs1457", 32'(a_hs), 1);
    adv_to(1458); chk("a_hs1458", 32'(a_hs), 0);
    adv_to(1502); chk("b_hs_pre", 32'(b_hs), 0); chk("b_vs_pre", 32'(b_vs), 0); chk("b_row_pre", 32'(b_row), 9);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_hs", 32'(b_hs), 1);
    chk("arst_vs", 32'(b_vs), 1);
    chk("arst_col", 32'(b_col), 0);
    chk("arst_row", 32'(b_row), 0);
    chk("arst_a_col", 32'(a_col), 0);
    @(negedge clk);
    rst_n = 1'b1;
    qstep(1);    chk("q_col1", 32'(b_col), 1); chk("q_von1", 32'(b_von), 1);
    qstep(2);    chk("q_col2", 32'(b_col), 1);
    qstep(3);    chk("q_col3", 32'(b_col), 1);
    qstep(4);    chk("q_col4", 32'(b_col), 1);
    qstep(5);    chk("q_col5", 32'(b_col), 2);
    qstep(61);   chk("q_b_row61", 32'(b_row), 1); chk("q_b_col61", 32'(b_col), 0);
    qstep(381);  chk("q_ft381", 32'(b_ft), 1); chk("q_fc381", 32'(b_fc), 1);
    qstep(382);  chk("q_ft382", 32'(b_ft), 0);
    qstep(3196); chk("q_a_col3196", 32'(a_col), 799); chk("q_a_row3196", 32'(a_row), 0);
    qstep(3197); chk("q_a_col3197", 32'(a_col), 0); chk("q_a_row3197", 32'(a_row), 1);
    qstep(3400);
    force dut_b.r_frame_count = 16'hFFFF;
    #1 release dut_b.r_frame_count;
    qstep(3452); chk("wrap_pre", 32'(b_fc), 32'hFFFF); chk("wrap_ft_pre", 32'(b_ft), 0);
    qstep(3453); chk("wrap_fc", 32'(b_fc), 0); chk("wrap_ft", 32'(b_ft), 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
